// File: rtl/mul_div_arbiter.sv
// Round-robin arbiter that shares one floating-point mul/div unit between
// N_REQ valid/ready requesters, one operation in flight at a time.
`timescale 1ns/1ps

module mul_div_arbiter #(
    parameter int N_REQ   = 2,
    parameter int LATENCY = 1,
    parameter int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    input  logic [N_REQ-1:0]     req_sel,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [31:0]          rsp_r,
    output logic [4:0]           rsp_flags,
    output logic [IDX_W-1:0]     rsp_id,
    output logic                 md_en,
    output logic                 md_sel,
    output logic [31:0]          md_a,
    output logic [31:0]          md_b,
    input  logic [31:0]          md_r,
    input  logic [4:0]           md_flags,
    output logic                 busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             md_en_q, md_en_d;
    logic             md_sel_q, md_sel_d;
    logic [31:0]      md_a_q, md_a_d;
    logic [31:0]      md_b_q, md_b_d;
    logic [31:0]      rsp_r_q, rsp_r_d;
    logic [4:0]       rsp_flags_q, rsp_flags_d;
    logic [IDX_W-1:0] rsp_id_q, rsp_id_d;

    logic             grant_found_s;
    logic [IDX_W-1:0] grant_idx_s;
    logic [IDX_W-1:0] next_ptr_s;
    logic [31:0]      a_arr_s [N_REQ];
    logic [31:0]      b_arr_s [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign a_arr_s[gi] = req_a[32*gi +: 32];
        assign b_arr_s[gi] = req_b[32*gi +: 32];
    end

    assign next_ptr_s = (rsp_id_q == IDX_W'(N_REQ - 1)) ? '0 : rsp_id_q + IDX_W'(1);

    // Round-robin search: walk downwards so the candidate closest to rr_ptr wins.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            logic [IDX_W-1:0] cand;
            cand          = IDX_W'((int'(rr_ptr_q) + k) % N_REQ);
            grant_found_s = grant_found_s | req_valid[cand];
            grant_idx_s   = req_valid[cand] ? cand : grant_idx_s;
        end
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (arst && (state_q == ST_IDLE) && grant_found_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
        if (state_q == ST_RESP) begin
            rsp_valid[rsp_id_q] = 1'b1;
        end else begin
            rsp_valid = '0;
        end
    end

    // Next-state and datapath capture.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        md_en_d     = md_en_q;
        md_sel_d    = md_sel_q;
        md_a_d      = md_a_q;
        md_b_d      = md_b_q;
        rsp_r_d     = rsp_r_q;
        rsp_flags_d = rsp_flags_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    md_a_d   = a_arr_s[grant_idx_s];
                    md_b_d   = b_arr_s[grant_idx_s];
                    md_sel_d = req_sel[grant_idx_s];
                    md_en_d  = 1'b1;
                    rsp_id_d = grant_idx_s;
                    cnt_d    = CNT_INIT;
                    state_d  = ST_WAIT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_r_d     = md_r;
                    rsp_flags_d = md_flags;
                    md_en_d     = 1'b0;
                    rr_ptr_d    = next_ptr_s;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready[rsp_id_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                md_en_d = 1'b0;
            end
        endcase
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= 4'd0;
            md_en_q     <= 1'b0;
            md_sel_q    <= 1'b0;
            md_a_q      <= 32'd0;
            md_b_q      <= 32'd0;
            rsp_r_q     <= 32'd0;
            rsp_flags_q <= 5'd0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            md_en_q     <= md_en_d;
            md_sel_q    <= md_sel_d;
            md_a_q      <= md_a_d;
            md_b_q      <= md_b_d;
            rsp_r_q     <= rsp_r_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign md_en     = md_en_q;
    assign md_sel    = md_sel_q;
    assign md_a      = md_a_q;
    assign md_b      = md_b_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
